// File: rtl/fu_load_nb_pkg.sv
// fu_load_nb_pkg: entry-state and access-size enums shared by the non-blocking load unit
package fu_load_nb_pkg;
  typedef enum logic [1:0] {FREE, LOOKUP, WAIT, DONE} ld_entry_state_e;
  typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} ld_size_e;
endpackage

// File: rtl/fu_load_nb_if.sv
// fu_load_nb_if: load-unit bus (squash, issue, sq probe, dcache, refill broadcast, completion, perf); slave = load unit, master = environment
interface fu_load_nb_if #(
  parameter int XLEN = 32,
  parameter int TAG_W = 5,
  parameter int PRF_W = 6
);
  logic squash;
  logic iss_valid;
  logic iss_ready;
  logic [XLEN-1:0] iss_base;
  logic [XLEN-1:0] iss_imm;
  logic [1:0] iss_size;
  logic iss_unsigned;
  logic [TAG_W-1:0] iss_rob;
  logic [PRF_W-1:0] iss_prf;
  logic sq_req_valid;
  logic [XLEN-1:0] sq_req_addr;
  logic [TAG_W-1:0] sq_req_rob;
  logic sq_fwd_hit;
  logic [XLEN-1:0] sq_fwd_data;
  logic dc_rd_en;
  logic [XLEN-1:0] dc_addr;
  logic dc_hit;
  logic [XLEN-1:0] dc_rd_data;
  logic brd_valid;
  logic [XLEN-1:0] brd_addr;
  logic [XLEN-1:0] brd_data;
  logic cmp_req;
  logic cmp_grant;
  logic [TAG_W-1:0] cmp_rob;
  logic [PRF_W-1:0] cmp_prf;
  logic [XLEN-1:0] cmp_value;
  logic [31:0] perf_hit_cnt;
  logic [31:0] perf_miss_cnt;
  logic [31:0] perf_fwd_cnt;
  modport slave (
    input squash, iss_valid, iss_base, iss_imm, iss_size, iss_unsigned, iss_rob, iss_prf,
    input sq_fwd_hit, sq_fwd_data, dc_hit, dc_rd_data, brd_valid, brd_addr, brd_data, cmp_grant,
    output iss_ready, sq_req_valid, sq_req_addr, sq_req_rob, dc_rd_en, dc_addr,
    output cmp_req, cmp_rob, cmp_prf, cmp_value, perf_hit_cnt, perf_miss_cnt, perf_fwd_cnt
  );
  modport master (
    output squash, iss_valid, iss_base, iss_imm, iss_size, iss_unsigned, iss_rob, iss_prf,
    output sq_fwd_hit, sq_fwd_data, dc_hit, dc_rd_data, brd_valid, brd_addr, brd_data, cmp_grant,
    input iss_ready, sq_req_valid, sq_req_addr, sq_req_rob, dc_rd_en, dc_addr,
    input cmp_req, cmp_rob, cmp_prf, cmp_value, perf_hit_cnt, perf_miss_cnt, perf_fwd_cnt
  );
endinterface

// File: rtl/fu_load_nb_align.sv
// ld_align: per-lane byte/half/word extraction with sign/zero extension (word, off, size, uns -> value), one lane per load entry
module ld_align
  import fu_load_nb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int N = 1
) (
  input  logic [XLEN-1:0] word [N],
  input  logic [1:0]      off [N],
  input  ld_size_e        size [N],
  input  logic            uns [N],
  output logic [XLEN-1:0] value [N]
);
  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [7:0] b;
    logic [15:0] h;
    assign b = word[g][{off[g], 3'b000} +: 8];
    assign h = word[g][{off[g][1], 4'b0000} +: 16];
    assign value[g] = size[g] == BYTE ? {{(XLEN-8){~uns[g] & b[7]}}, b} :
                      size[g] == HALF ? {{(XLEN-16){~uns[g] & h[15]}}, h} : word[g];
  end
endmodule

// File: rtl/fu_load_nb.sv
// fu_load_nb: non-blocking load unit, DEPTH entries (ports clk, rst, bus = fu_load_nb_if.slave); LD_PERF_CNT_EN enables hit/miss/fwd counters
module fu_load_nb
  import fu_load_nb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 5,
  parameter int PRF_W = 6
) (
  input logic clk,
  input logic rst,
  fu_load_nb_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  ld_entry_state_e state [DEPTH];
  logic [XLEN-1:0] addr [DEPTH];
  ld_size_e size [DEPTH];
  logic uns [DEPTH];
  logic [TAG_W-1:0] rob [DEPTH];
  logic [PRF_W-1:0] prf [DEPTH];
  logic [XLEN-1:0] value [DEPTH];
  logic [IW-1:0] free_idx, lk_idx, dn_idx;
  logic free_any, lk_any, dn_any, lk_done;
  logic [DEPTH-1:0] brd_match;
  logic [XLEN-1:0] lk_word, lk_waddr;
  logic [XLEN-1:0] lane_word [DEPTH];
  logic [XLEN-1:0] lane_val [DEPTH];
  logic [1:0] lane_off [DEPTH];
  always_comb begin
    free_any = 1'b0;
    lk_any = 1'b0;
    dn_any = 1'b0;
    free_idx = '0;
    lk_idx = '0;
    dn_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (state[i] == FREE) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
      if (state[i] == LOOKUP) begin
        lk_any = 1'b1;
        lk_idx = IW'(i);
      end
      if (state[i] == DONE) begin
        dn_any = 1'b1;
        dn_idx = IW'(i);
      end
    end
  end
  assign lk_word = bus.sq_fwd_hit ? bus.sq_fwd_data : bus.dc_hit ? bus.dc_rd_data : bus.brd_data;
  assign lk_done = bus.sq_fwd_hit | bus.dc_hit | brd_match[lk_idx];
  // the looking-up entry aligns its resolved word; every other lane aligns the refill word
  always_comb begin
    brd_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      brd_match[i] = bus.brd_valid && bus.brd_addr == {addr[i][XLEN-1:2], 2'b00};
      lane_word[i] = (lk_any && lk_idx == IW'(i)) ? lk_word : bus.brd_data;
      lane_off[i] = addr[i][1:0];
    end
  end
  ld_align #(.XLEN(XLEN), .N(DEPTH)) u_align (
    .word(lane_word),
    .off(lane_off),
    .size(size),
    .uns(uns),
    .value(lane_val)
  );
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst || bus.squash) begin
        state[i] <= FREE;
      end else if (state[i] == FREE && bus.iss_valid && free_idx == IW'(i)) begin
        state[i] <= LOOKUP;
        addr[i] <= bus.iss_base + bus.iss_imm;
        size[i] <= ld_size_e'(bus.iss_size);
        uns[i] <= bus.iss_unsigned;
        rob[i] <= bus.iss_rob;
        prf[i] <= bus.iss_prf;
      end else if (state[i] == LOOKUP && lk_idx == IW'(i)) begin
        state[i] <= lk_done ? DONE : WAIT;
        value[i] <= lane_val[i];
      end else if (state[i] == WAIT && brd_match[i]) begin
        state[i] <= DONE;
        value[i] <= lane_val[i];
      end else if (state[i] == DONE && bus.cmp_grant && dn_idx == IW'(i)) begin
        state[i] <= FREE;
      end
    end
  end
  assign lk_waddr = lk_any ? {addr[lk_idx][XLEN-1:2], 2'b00} : '0;
  assign bus.iss_ready = free_any;
  assign bus.sq_req_valid = lk_any;
  assign bus.dc_rd_en = lk_any;
  assign bus.sq_req_addr = lk_waddr;
  assign bus.dc_addr = lk_waddr;
  assign bus.sq_req_rob = lk_any ? rob[lk_idx] : '0;
  assign bus.cmp_req = dn_any;
  assign bus.cmp_rob = dn_any ? rob[dn_idx] : '0;
  assign bus.cmp_prf = dn_any ? prf[dn_idx] : '0;
  assign bus.cmp_value = dn_any ? value[dn_idx] : '0;
`ifdef LD_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt, fwd_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt <= '0;
      miss_cnt <= '0;
      fwd_cnt <= '0;
    end else if (lk_any && !bus.squash) begin
      fwd_cnt <= fwd_cnt + 32'(bus.sq_fwd_hit);
      hit_cnt <= hit_cnt + 32'(!bus.sq_fwd_hit && bus.dc_hit);
      miss_cnt <= miss_cnt + 32'(!bus.sq_fwd_hit && !bus.dc_hit);
    end
  end
  assign bus.perf_hit_cnt = hit_cnt;
  assign bus.perf_miss_cnt = miss_cnt;
  assign bus.perf_fwd_cnt = fwd_cnt;
`else
  assign bus.perf_hit_cnt = '0;
  assign bus.perf_miss_cnt = '0;
  assign bus.perf_fwd_cnt = '0;
`endif
endmodule
